instr_loader: RTL
=================

// Module: instr_loader
// PURPOSE
//  Writer side of the instruction-memory interface that the processor controller reads.
//  Receives a byte stream over a valid/ready handshake and packs bytes into 16-bit instruction words.
//  Writes each word to instruction RAM at consecutive addresses from 0.
//  Holds the CPU in reset until the program ends, then releases it.
// PARAMETERS
//  ADDR_W   8     instruction RAM address width
//  DEPTH    256   max words loaded; DEPTH <= 2**ADDR_W
//  HALT_OP  4'h5  opcode (word[15:12]) that terminates the load
// PORTS
//  clk         in   1        clock, all logic on posedge
//  Reset       in   1        synchronous, active-high reset
//  start       in   1        begin a load; sampled only in IDLE or DONE
//  in_byte     in   8        stream byte; high byte of each word first
//  in_valid    in   1        in_byte is valid
//  in_ready    out  1        loader accepts in_byte this cycle
//  I_addr      out  ADDR_W   instruction RAM write address
//  I_data      out  16       instruction RAM write data
//  I_wr        out  1        instruction RAM write enable, one cycle per word
//  cpu_reset   out  1        held high until DONE; drives controller Reset
//  busy        out  1        load in progress (states HI, LO, WRITE)
//  done        out  1        load complete
//  error       out  1        sticky; illegal opcode seen (OPCODE_CHECK_EN only)
//  word_count  out  ADDR_W+1 number of words written in the current load
// BEHAVIOUR
//  Reset: state=IDLE; cpu_reset=1; all other outputs 0; ptr=0.
//   RAM contents are not cleared.
//  States: IDLE, HI, LO, WRITE, DONE.
//  IDLE: in_ready=0. start -> HI, ptr=0, word_count=0, error=0.
//  HI: in_ready=1. in_valid -> latch word[15:8], go to LO.
//  LO: in_ready=1. in_valid -> latch word[7:0], go to WRITE.
//  WRITE: I_wr=1, I_addr=ptr, I_data=word. ptr++ and word_count++ at the clock edge.
//   Word reaches RAM the cycle after its low byte is accepted.
//   Next state is DONE if word[15:12]==HALT_OP or ptr==DEPTH-1; otherwise HI.
//  DONE: done=1, cpu_reset=0. A new start -> HI, cpu_reset=1, done=0, counters cleared.
//  Outside WRITE: I_wr=0 and I_addr/I_data hold their last values.
//  Handshake: a byte transfers only when in_valid && in_ready. Idle cycles between bytes are allowed.
//  start while busy is ignored. Bytes presented in IDLE/DONE are not accepted (in_ready=0).
//  Capacity: the word written at ptr==DEPTH-1 ends the load; there is no wrap.
//  Reset during a load aborts it: partial word dropped, words already written remain, cpu_reset=1.
//  cpu_reset is registered and glitch-free; it falls on the cycle state enters DONE.
// CONFIGURATION
//  OPCODE_CHECK_EN defined:
//   In WRITE, an opcode outside 0..5 sets error (sticky until next start).
//   The word is written as 16'h0000 (NOOP).
//  OPCODE_CHECK_EN undefined:
//   Words are written verbatim; error is tied 0.
// STRUCTURE
//  Shared package / header, also used by the controller:
//   - opcode constants OP_NOOP=0, OP_STORE=1, OP_LOAD=2, OP_ADD=3, OP_SUB=4, OP_HALT=5
//   - INSTR_W=16
//  Loader state encoding stays local.
//  Sub-module instr_word_packer: byte-pair to 16-bit word register with hi/lo load enables.
//  Everything else (FSM, counters) lives in instr_loader.
// TESTING
//  1. Reset held 2 cycles -> cpu_reset=1, done=0, busy=0, I_wr=0, word_count=0.
//  2. start, then bytes 21 04 31 25 50 00 -> writes:
//     addr0=16'h2104, addr1=16'h3125, addr2=16'h5000; done=1, cpu_reset=0, word_count=3.
//  3. in_valid toggled every other cycle through case 2 -> identical writes.
//     in_ready never accepts two bytes per cycle.
//  4. DEPTH=4, stream with no HALT -> exactly 4 writes, addr 0..3, then DONE.
//     Further bytes not accepted.
//  5. Reset after byte 0x31 of case 2 -> no write at addr1, cpu_reset=1, state IDLE.
//     A new start reloads from addr0.
//  6. OPCODE_CHECK_EN, word 16'hA123 -> error=1, addr written with 16'h0000.
//     Without the macro -> 16'hA123 written, error=0.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// ============================================================================
//  Module   : instr_loader_pkg
//  Purpose  : Instruction-set constants shared by the loader and the controller.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package instr_loader_pkg;

   localparam int INSTR_W = 16;

   localparam logic [3:0] OP_NOOP  = 4'h0;
   localparam logic [3:0] OP_STORE = 4'h1;
   localparam logic [3:0] OP_LOAD  = 4'h2;
   localparam logic [3:0] OP_ADD   = 4'h3;
   localparam logic [3:0] OP_SUB   = 4'h4;
   localparam logic [3:0] OP_HALT  = 4'h5;

   typedef logic [INSTR_W-1:0] instr_t;

   function automatic logic op_legal(input logic [3:0] op);
      return (op <= OP_HALT);
   endfunction

endpackage

`default_nettype wire

// File: rtl/instr_word_packer.sv
// ============================================================================
//  Module   : instr_word_packer
//  Purpose  : Stages the high byte, then loads a full 16-bit word on the low byte.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module instr_word_packer
   import instr_loader_pkg::*;
(
   input  logic         clk,
   input  logic         Reset,
   input  logic         hi_en,
   input  logic         lo_en,
   input  logic         squash,
   input  logic [7:0]   in_byte,
   output logic [3:0]   opcode,
   output instr_t       word
);

   logic [7:0] r_hi;

   // The word register only changes on a low-byte load, so it holds between writes.
   always_ff @(posedge clk) begin
      if (Reset) begin
         r_hi <= 8'h00;
         word <= '0;
      end else begin
         if (hi_en)
            r_hi <= in_byte;
         if (lo_en)
            word <= squash ? instr_t'(OP_NOOP) << 12 : {r_hi, in_byte};
      end
   end

   assign opcode = r_hi[7:4];

endmodule

`default_nettype wire

// File: rtl/instr_loader.sv
// ============================================================================
//  Module   : instr_loader
//  Purpose  : Packs a byte stream into instruction words, writes them to RAM from
//             address 0, and holds the CPU in reset until the load completes.
//             Optional macro OPCODE_CHECK_EN: illegal opcodes are written as NOOP
//             and raise a sticky error.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module instr_loader
   import instr_loader_pkg::*;
#(
   parameter int         ADDR_W  = 8,
   parameter int         DEPTH   = 256,
   parameter logic [3:0] HALT_OP = OP_HALT
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic              start,
   input  logic [7:0]        in_byte,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ADDR_W-1:0] I_addr,
   output logic [15:0]       I_data,
   output logic              I_wr,
   output logic              cpu_reset,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   word_count
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HI    = 3'd1,
      S_LO    = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] c_last = ADDR_W'(DEPTH - 1);

   state_t            r_state;
   logic [ADDR_W-1:0] r_ptr;
   logic              r_halt;
   logic              r_error;
   logic              w_hi_en;
   logic              w_lo_en;
   logic              w_bad;
   logic [3:0]        w_opcode;
   instr_t            w_word;

   assign w_hi_en = (r_state == S_HI) && in_valid;
   assign w_lo_en = (r_state == S_LO) && in_valid;

`ifdef OPCODE_CHECK_EN
   assign w_bad = !op_legal(w_opcode);
`else
   assign w_bad = 1'b0;
`endif

   instr_word_packer u_packer (
      .clk     (clk),
      .Reset   (Reset),
      .hi_en   (w_hi_en),
      .lo_en   (w_lo_en),
      .squash  (w_bad),
      .in_byte (in_byte),
      .opcode  (w_opcode),
      .word    (w_word)
   );

   assign I_data = w_word;
   assign error  = r_error;

   // Outputs are set on the transition into each state so they stay glitch-free.
   always_ff @(posedge clk) begin
      if (Reset) begin
         r_state    <= S_IDLE;
         r_ptr      <= '0;
         r_halt     <= 1'b0;
         r_error    <= 1'b0;
         in_ready   <= 1'b0;
         I_addr     <= '0;
         I_wr       <= 1'b0;
         cpu_reset  <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         word_count <= '0;
      end else begin
         I_wr <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_state    <= S_HI;
                  r_ptr      <= '0;
                  r_error    <= 1'b0;
                  word_count <= '0;
                  in_ready   <= 1'b1;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  cpu_reset  <= 1'b1;
               end
            end
            S_HI: begin
               if (in_valid)
                  r_state <= S_LO;
            end
            S_LO: begin
               if (in_valid) begin
                  r_state  <= S_WRITE;
                  in_ready <= 1'b0;
                  I_wr     <= 1'b1;
                  I_addr   <= r_ptr;
                  r_halt   <= (w_opcode == HALT_OP);
                  if (w_bad)
                     r_error <= 1'b1;
               end
            end
            S_WRITE: begin
               r_ptr      <= r_ptr + 1'b1;
               word_count <= word_count + 1'b1;
               if (r_halt || (r_ptr == c_last)) begin
                  r_state   <= S_DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  cpu_reset <= 1'b0;
               end else begin
                  r_state  <= S_HI;
                  in_ready <= 1'b1;
               end
            end
            default: begin
               r_state  <= S_IDLE;
               in_ready <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
